bcd_seg7_scan: RTL and testbench

BCD_SEG7_SCAN -- requirements
Module: bcd_seg7_scan

---
 rtl/bcd_seg7_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/bcd_seg7_scan.sv | 112 +++++++++++
 tb/tb_bcd_seg7_scan.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg7_pkg.sv
// Shared constants for the 3-digit multiplexed seven-segment scanner.
//
// Contents:
//   SEG_0 .. SEG_9 : active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_DASH       : pattern shown for non-decimal nibbles 10..15
//   SEG_BLANK      : all segments off, used for leading-zero blanking
//   DIV_DEFAULT    : default clk cycles per digit slot
package bcd_seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int DIV_DEFAULT = 1000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
//
// Ports:
//   digit : 4-bit nibble to display
//   seg   : active-high segment pattern {g,f,e,d,c,b,a}; 10..15 show a dash
module bcd_to_seg7
  import bcd_seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed driver for a 3-digit common-cathode style display.
// A prescaler divides clk into digit slots of DIV cycles; the digit index
// walks ones -> tens -> hundreds. bcd_in is captured into a snapshot once
// per frame so a counter changing mid-frame never tears the display.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous reset, ACTIVE-LOW despite its name
//   bcd_in     : {hundreds, tens, ones} BCD digits
//   blank_lz   : 1 = blank leading zeros (sampled live)
//   seg        : registered segment drive {g,f,e,d,c,b,a}, active-high
//   an         : registered one-hot digit enable, an[0] = ones
//   frame_done : one-cycle pulse after each full 3-digit scan
module bcd_seg7_scan
  import bcd_seg7_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_done
);

  localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

  logic [15:0] presc;
  logic [1:0]  idx;
  logic [11:0] snap;
  logic        tick;
  logic        frame_end;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_next;
  logic [2:0]  an_next;

  assign tick      = (presc == PRESC_MAX);
  assign frame_end = tick && (idx == 2'd2);

  // Slot prescaler: free-running 0..DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 16'd1;
  end

  // Digit index 0..2; the unused code 3 is recovered on the very next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             idx <= 2'd0;
    else if (idx == 2'd3)   idx <= 2'd0;
    else if (tick)          idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  // Snapshot is taken at the end of the hundreds slot, and frame_done
  // pulses in the cycle right after the capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) snap <= bcd_in;
    end
  end

  // Digit select and leading-zero blanking. A nibble of 10..15 is nonzero,
  // so it never triggers blanking of itself or of the digits below it.
  always_comb begin
    digit   = snap[3:0];
    an_next = 3'b001;
    blank   = 1'b0;
    case (idx)
      2'd1: begin
        digit   = snap[7:4];
        an_next = 3'b010;
        blank   = blank_lz && (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0);
      end
      2'd2: begin
        digit   = snap[11:8];
        an_next = 3'b100;
        blank   = blank_lz && (snap[11:8] == 4'd0);
      end
      default: begin
        digit   = snap[3:0];
        an_next = 3'b001;
        blank   = 1'b0;
      end
    endcase
    seg_next = blank ? SEG_BLANK : dec_seg;
  end

  bcd_to_seg7 u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  // Output registers give glitch-free pins with one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= '0;
      an  <= '0;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan with DIV=4. The reference model
// works purely from elapsed cycles since reset release: slot number,
// frame boundaries and the snapshot are derived with plain arithmetic.
module tb_bcd_seg7_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 3 * DIV;

  logic        clk;
  logic        reset;
  logic [11:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_done;

  int n_cmp;
  int n_bad;

  // Model state
  int          k;
  logic [11:0] msnap;
  logic [6:0]  exp_seg;
  logic [2:0]  exp_an;
  logic        exp_fd;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  bcd_seg7_scan #(.DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A digit is blank when blanking is on, it is not the ones digit, and
  // it together with every more significant digit is zero.
  function automatic logic [6:0] ref_seg(input logic [11:0] s, input logic bl, input int slot);
    logic [11:0] upper;
    upper = s >> (4 * slot);
    if (bl && slot != 0 && upper == 12'd0) return 7'h00;
    return seg_tbl[upper[3:0]];
  endfunction

  // Drive inputs, advance one clock, predict outputs, sample 1 ns later.
  task automatic step(input logic [11:0] b, input logic bl);
    int slot;
    bcd_in   = b;
    blank_lz = bl;
    @(posedge clk);
    k++;
    slot    = ((k - 1) / DIV) % 3;
    exp_an  = 3'b001 << slot;
    exp_seg = ref_seg(msnap, bl, slot);
    exp_fd  = (k % FRAME == 0);
    if (exp_fd) msnap = b;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    k     = 0;
    msnap = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (seg !== 7'h00) begin n_bad++; $display("[TB] FAIL reset_seg: got %h expected 00", seg); end
    n_cmp++; if (an !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_an: got %b expected 000", an); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fd: got %b expected 0", frame_done); end
    @(negedge clk);
    reset = 1'b1;
    k     = 0;
    msnap = '0;
    step(12'h456, 1'b1);
    n_cmp++; if (an !== 3'b001) begin n_bad++; $display("[TB] FAIL first_an: got %b expected 001", an); end
    n_cmp++; if (seg !== 7'h3F) begin n_bad++; $display("[TB] FAIL first_seg: got %h expected 3f", seg); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL first_fd: got %b expected 0", frame_done); end
  endtask

  task automatic test_count_123();
    logic [6:0] hard_seg [3] = '{7'h4F, 7'h5B, 7'h06};
    logic [2:0] hard_an  [3] = '{3'b001, 3'b010, 3'b100};
    apply_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(12'h123, 1'b0);
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("[TB] FAIL c123_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("[TB] FAIL c123_an k=%0d: got %b expected %b", k, an, exp_an); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("[TB] FAIL c123_fd k=%0d: got %b expected %b", k, frame_done, exp_fd); end
      if (k > FRAME) begin
        n_cmp++;
        if (seg !== hard_seg[(k - FRAME - 1) / DIV] || an !== hard_an[(k - FRAME - 1) / DIV]) begin
          n_bad++;
          $display("[TB] FAIL c123_fixed k=%0d: got %h/%b expected %h/%b", k, seg, an,
                   hard_seg[(k - FRAME - 1) / DIV], hard_an[(k - FRAME - 1) / DIV]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [11:0] vals [3] = '{12'h007, 12'h000, 12'h0A0};
    for (int v = 0; v < 3; v++) begin
      apply_reset();
      for (int i = 0; i < 2 * FRAME; i++) begin
        step(vals[v], 1'b1);
        n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("[TB] FAIL blank_seg v=%h k=%0d: got %h expected %h", vals[v], k, seg, exp_seg); end
        n_cmp++; if (an !== exp_an) begin n_bad++; $display("[TB] FAIL blank_an v=%h k=%0d: got %b expected %b", vals[v], k, an, exp_an); end
      end
    end
  endtask

  task automatic test_no_tear();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int i = 0; i < 4 * FRAME; i++) begin
      // Switch to 999 part-way through the tens slot of the third frame.
      step((k < 2 * FRAME + DIV + 2) ? 12'h111 : 12'h999, 1'b0);
      if (frame_done === 1'b1) pulses++;
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("[TB] FAIL tear_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("[TB] FAIL tear_fd k=%0d: got %b expected %b", k, frame_done, exp_fd); end
      if (k > 2 * FRAME && k <= 3 * FRAME) begin
        n_cmp++; if (seg !== 7'h06) begin n_bad++; $display("[TB] FAIL tear_old k=%0d: got %h expected 06", k, seg); end
      end
      if (k > 3 * FRAME) begin
        n_cmp++; if (seg !== 7'h6F) begin n_bad++; $display("[TB] FAIL tear_new k=%0d: got %h expected 6f", k, seg); end
      end
    end
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("[TB] FAIL tear_pulses: got %0d expected 4", pulses); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 2 * DIV + 1; i++) step(12'h555, 1'b0);
    n_cmp++; if (an !== 3'b100) begin n_bad++; $display("[TB] FAIL mid_pre_an: got %b expected 100", an); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (seg !== 7'h00) begin n_bad++; $display("[TB] FAIL mid_seg: got %h expected 00", seg); end
    n_cmp++; if (an !== 3'b000) begin n_bad++; $display("[TB] FAIL mid_an: got %b expected 000", an); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_fd: got %b expected 0", frame_done); end
    @(negedge clk);
    reset = 1'b1;
    k     = 0;
    msnap = '0;
    for (int i = 0; i < FRAME; i++) begin
      step(12'h555, 1'b0);
      if (k == 1) begin
        n_cmp++; if (an !== 3'b001) begin n_bad++; $display("[TB] FAIL mid_restart_an: got %b expected 001", an); end
      end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("[TB] FAIL mid_fd k=%0d: got %b expected %b", k, frame_done, exp_fd); end
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("[TB] FAIL mid_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      step(12'($urandom), 1'($urandom));
      n_cmp++; if (!$onehot(an)) begin n_bad++; $display("[TB] FAIL rand_onehot k=%0d: got %b expected one-hot", k, an); end
      n_cmp++; if (an !== exp_an) begin n_bad++; $display("[TB] FAIL rand_an k=%0d: got %b expected %b", k, an, exp_an); end
      n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("[TB] FAIL rand_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
      n_cmp++; if (frame_done !== exp_fd) begin n_bad++; $display("[TB] FAIL rand_fd k=%0d: got %b expected %b", k, frame_done, exp_fd); end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    k        = 0;
    msnap    = '0;
    reset    = 1'b1;
    bcd_in   = '0;
    blank_lz = 1'b0;
    #3;
    test_reset();
    test_count_123();
    test_blanking();
    test_no_tear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
